// File: rtl/seq_divider_if.sv
// Handshake bundle for seq_divider: operand request channel and result channel.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, 2*WIDTH / WIDTH, one quotient bit per cycle MSB first.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider_if.slave  bus
);
   localparam int unsigned DW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   part_q, part_d;
   logic [DW-1:0]      shift_q, shift_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [DW-1:0]      quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               dbz_q, dbz_d;

   logic               accept;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   diff;
   logic               trial_neg;
   logic [WIDTH-1:0]   part_next;
   logic [DW-1:0]      shift_next;

   always_comb begin
      accept     = bus.in_valid && bus.in_ready;
      shifted    = {part_q, shift_q[DW-1]};
      trial_neg  = shifted < {1'b0, dvsr_q};
      // A kept difference is always < divisor, so the WIDTH-bit modular subtract is exact.
      diff       = shifted[WIDTH-1:0] - dvsr_q;
      part_next  = trial_neg ? shifted[WIDTH-1:0] : diff;
      shift_next = {shift_q[DW-2:0], ~trial_neg};

      state_d     = state_q;
      part_d      = part_q;
      shift_d     = shift_q;
      dvsr_d      = dvsr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               dvsr_d = bus.divisor;
               if (bus.divisor != '0) begin
                  state_d = RUN;
                  part_d  = '0;
                  shift_d = bus.dividend;
                  count_d = CW'(DW);
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  quot_d      = '1;
                  rem_d       = bus.dividend[WIDTH-1:0];
                  dbz_d       = 1'b1;
               end
            end
         end
         RUN: begin
            part_d  = part_next;
            shift_d = shift_next;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               quot_d      = shift_next;
               rem_d       = part_next;
               dbz_d       = 1'b0;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         part_q      <= '0;
         shift_q     <= '0;
         dvsr_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         part_q      <= part_d;
         shift_q     <= shift_d;
         dvsr_q      <= dvsr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dbz_q       <= dbz_d;
      end
   end

   assign bus.in_ready    = (state_q == IDLE) && !rst;
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed self-checking bench for seq_divider against plain-arithmetic division.
module tb_seq_divider;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned LAT   = 2 * WIDTH;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain unsigned division; divide by zero yields all ones and the low dividend half.
   function automatic void model(input logic [63:0] a, input logic [31:0] b,
                                 output logic [63:0] q, output logic [31:0] r,
                                 output logic z, output int lat);
      if (b == 32'd0) begin
         q = '1; r = a[31:0]; z = 1'b1; lat = 0;
      end else begin
         q = a / {32'd0, b};
         r = 32'(a % {32'd0, b});
         z = 1'b0; lat = LAT;
      end
   endfunction

   task automatic run_div(input logic [63:0] a, input logic [31:0] b, input int ready_delay,
                          output int lat, output logic [63:0] q, output logic [31:0] r,
                          output logic z);
      int n;
      n = 0;
      while (!bus.in_ready && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
      end
      bus.in_valid  = 1'b1;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 300) begin
         @(posedge clk); #1; lat++;
      end
      if (!bus.out_valid) begin
         checks++; errors++;
         $display("FAIL result_timeout: out_valid=%0b required 1", bus.out_valid);
      end
      q = bus.quotient;
      r = bus.remainder;
      z = bus.div_by_zero;
      repeat (ready_delay) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.quotient !== 64'd0 || bus.remainder !== 32'd0 ||
          bus.div_by_zero !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: ov=%0b q=%h r=%h z=%0b rdy=%0b required 0 0 0 0 0",
                  bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: in_ready=%0b required 1", bus.in_ready);
      end
   endtask

   task automatic check_case(input string name, input logic [63:0] a, input logic [31:0] b,
                             input int ready_delay);
      int lat, elat;
      logic [63:0] q, eq;
      logic [31:0] r, er;
      logic z, ez;
      model(a, b, eq, er, ez, elat);
      run_div(a, b, ready_delay, lat, q, r, z);
      checks++;
      if (q !== eq || r !== er || z !== ez) begin
         errors++;
         $display("FAIL %s result: q=%h r=%h z=%0b required q=%h r=%h z=%0b",
                  name, q, r, z, eq, er, ez);
      end
      checks++;
      if (lat !== elat) begin
         errors++;
         $display("FAIL %s latency: %0d required %0d", name, lat, elat);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s consume: out_valid=%0b in_ready=%0b required 0 1",
                  name, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_small();
      int lat;
      logic [63:0] q;
      logic [31:0] r;
      logic z;
      run_div(64'd100, 32'd7, 0, lat, q, r, z);
      checks++;
      if (q !== 64'd14 || r !== 32'd2 || z !== 1'b0 || lat !== 64) begin
         errors++;
         $display("FAIL small_100_7: q=%0d r=%0d z=%0b lat=%0d required 14 2 0 64", q, r, z, lat);
      end
   endtask

   task automatic test_round_trip();
      check_case("round_trip", 64'd121212121 * 64'd123123123, 32'd123123123, 1);
   endtask

   task automatic test_extremes();
      int lat;
      logic [63:0] q;
      logic [31:0] r;
      logic z;
      run_div('1, 32'hFFFF_FFFF, 0, lat, q, r, z);
      checks++;
      if (q !== 64'h0000_0001_0000_0001 || r !== 32'd0) begin
         errors++;
         $display("FAIL max_by_max: q=%h r=%h required 0000000100000001 0", q, r);
      end
      run_div('1, 32'd1, 2, lat, q, r, z);
      checks++;
      if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 32'd0) begin
         errors++;
         $display("FAIL max_by_one: q=%h r=%h required ffffffffffffffff 0", q, r);
      end
      run_div(64'd5, 32'd9, 0, lat, q, r, z);
      checks++;
      if (q !== 64'd0 || r !== 32'd5) begin
         errors++;
         $display("FAIL five_by_nine: q=%h r=%h required 0 5", q, r);
      end
   endtask

   task automatic test_div_zero();
      int lat;
      logic [63:0] q;
      logic [31:0] r;
      logic z;
      run_div(64'h1234, 32'd0, 0, lat, q, r, z);
      checks++;
      if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 32'h1234 || z !== 1'b1 || lat !== 0) begin
         errors++;
         $display("FAIL div_zero: q=%h r=%h z=%0b lat=%0d required ffffffffffffffff 1234 1 0",
                  q, r, z, lat);
      end
   endtask

   task automatic test_backpressure();
      int n;
      bus.in_valid = 1'b1; bus.dividend = 64'd1000; bus.divisor = 32'd10; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 300) begin
         @(posedge clk); #1; n++;
      end
      bus.in_valid = 1'b1; bus.dividend = 64'd777; bus.divisor = 32'd5;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.quotient !== 64'd100 || bus.remainder !== 32'd0 ||
             bus.div_by_zero !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: ov=%0b q=%0d r=%0d z=%0b rdy=%0b required 1 100 0 0 0", i,
                     bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_consume: ov=%0b rdy=%0b required 0 1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept: in_ready=%0b required 0", bus.in_ready);
      end
      n = 0;
      while (!bus.out_valid && n < 300) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (bus.quotient !== 64'd155 || bus.remainder !== 32'd2 || n !== LAT) begin
         errors++;
         $display("FAIL bp_second: q=%0d r=%0d lat=%0d required 155 2 %0d",
                  bus.quotient, bus.remainder, n, LAT);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bus.in_valid = 1'b1; bus.dividend = 64'd1000; bus.divisor = 32'd3; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.quotient !== 64'd0 || bus.remainder !== 32'd0 ||
          bus.div_by_zero !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: ov=%0b q=%h r=%h z=%0b rdy=%0b required 0 0 0 0 0",
                  bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.in_ready);
      end
      rst = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_ready: in_ready=%0b required 1", bus.in_ready);
      end
      check_case("after_reset", 64'd100, 32'd7, 0);
   endtask

   task automatic test_random();
      logic [63:0] a;
      logic [31:0] b;
      int mode;
      for (int i = 0; i < 25; i++) begin
         mode = int'($urandom_range(0, 4));
         a = {$urandom, $urandom};
         case (mode)
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       begin b = $urandom | 32'h8000_0000; a = {32'd0, b} * {32'd0, $urandom}; end
            3:       begin b = $urandom; a = {$urandom, 32'd0} >> $urandom_range(0, 40); end
            default: b = $urandom;
         endcase
         check_case($sformatf("rand_%0d", i), a, b, int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      test_reset();
      test_small();
      test_round_trip();
      test_extremes();
      test_div_zero();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
